// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - op codes, FSM states and op classification for the HI/LO mul/div unit
// Purpose: shared definitions imported by hilo_iter_core and hilo_muldiv_unit.
// Contents: OP_* encodings (3 bits), state_t (IDLE/RUN/FIX), op classifier functions.
package hilo_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Ops that occupy the iterative engine (everything except MTHI/MTLO).
   function automatic logic is_engine_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
             (op == OP_DIVU) || (op == OP_MADD)  || (op == OP_MSUB);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// rtl/hilo_iter_core.sv - one-bit-per-cycle shift-add multiply / restoring divide on magnitudes
// Purpose: iterative datapath with its own iteration counter.
// Ports: Clk, Reset (async, active-high); load (latch operands), step (one iteration),
//        is_div (select divide on load), a (multiplicand/dividend), b (multiplier/divisor);
//        acc (2*WIDTH result: product, or {remainder, quotient}), last (current step is the final one).
module hilo_iter_core
   import hilo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc,
   output logic               last
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   opd;        // multiplicand (multiply) or divisor (divide)
   logic               div_mode;
   logic [CW-1:0]      count;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] acc_next;

   assign last = (count == CW'(WIDTH - 1));

   // Multiply: acc = {partial_high, multiplier bits still to consume}; add, then shift right.
   // Divide:   acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_trial = div_shift - {1'b0, opd};
      acc_next  = acc;
      if (div_mode) begin
         // Top bit of the trial is the borrow: set means the subtraction is rejected.
         if (!div_trial[WIDTH])
            acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         else
            acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_next = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         acc      <= '0;
         opd      <= '0;
         div_mode <= 1'b0;
         count    <= '0;
      end else if (load) begin
         div_mode <= is_div;
         opd      <= is_div ? b : a;
         acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
         count    <= '0;
      end else if (step) begin
         acc   <= acc_next;
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO registers with iterative signed/unsigned mul, div, madd, msub
// Purpose: accepts one-cycle start requests, runs the engine for WIDTH+1 edges, commits HI/LO.
// Ports: Clk, Reset (async, active-high); start, op[2:0], rs, rt (request);
//        busy (engine running, start ignored), done (one-cycle commit pulse), hi, lo (architectural).
module hilo_muldiv_unit
   import hilo_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t             state, state_next;
   logic               load, step, commit;
   logic [2:0]         op_q;
   logic               neg_a, neg_b, div_zero;
   logic               sgn, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] core_acc;
   logic               core_last;
   logic [2*WIDTH-1:0] prod, result;
   logic [WIDTH-1:0]   quo, rem;

   assign sgn   = is_signed_op(op);
   assign a_neg = sgn & rs[WIDTH-1];
   assign b_neg = sgn & rt[WIDTH-1];
   // Two's-complement negate of the most negative value is itself, which is its correct unsigned magnitude.
   assign a_mag = a_neg ? -rs : rs;
   assign b_mag = b_neg ? -rt : rt;
   assign busy  = (state != IDLE);

   hilo_iter_core #(.WIDTH(WIDTH)) u_core (
      .Clk    (Clk),
      .Reset  (Reset),
      .load   (load),
      .step   (step),
      .is_div (is_div_op(op)),
      .a      (a_mag),
      .b      (b_mag),
      .acc    (core_acc),
      .last   (core_last)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (start && is_engine_op(op)) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (core_last) state_next = FIX;
         end
         FIX: begin
            commit     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sign correction and accumulate, evaluated against the HI/LO present in FIX.
   always_comb begin
      prod = (neg_a ^ neg_b) ? -core_acc : core_acc;
      quo  = core_acc[WIDTH-1:0];
      rem  = core_acc[2*WIDTH-1:WIDTH];
      if (neg_a ^ neg_b) quo = -quo;
      if (neg_a)         rem = -rem;
      // Divide by zero: the remainder path already reproduces rs; force the quotient to all ones.
      if (div_zero)      quo = '1;
      case (op_q)
         OP_MADD:         result = {hi, lo} + prod;
         OP_MSUB:         result = {hi, lo} - prod;
         OP_DIV, OP_DIVU: result = {rem, quo};
         default:         result = prod;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         op_q     <= OP_MULT;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= commit;
         if (load) begin
            op_q     <= op;
            neg_a    <= a_neg;
            neg_b    <= b_neg;
            div_zero <= (rt == '0);
         end
         if (commit) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
         end else if (state == IDLE && start && op == OP_MTHI) begin
            hi <= rs;
         end else if (state == IDLE && start && op == OP_MTLO) begin
            lo <= rs;
         end
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
   import hilo_pkg::*;

   localparam int W = 32;

   logic         Clk = 1'b0;
   logic         Reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op = OP_MULT;
   logic [W-1:0] rs = '0;
   logic [W-1:0] rt = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   hilo_muldiv_unit #(.WIDTH(W)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .start (start),
      .op    (op),
      .rs    (rs),
      .rt    (rt),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string        name;
      logic [2:0]   op;
      logic [W-1:0] rs, rt, pre_hi, pre_lo, exp_hi, exp_lo;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Start is sampled at exactly one rising edge.
   task automatic pulse(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge Clk);
      start = 1'b1; op = o; rs = a; rt = b;
      @(posedge Clk);
      #1 start = 1'b0;
   endtask

   task automatic preload(input logic [W-1:0] h, input logic [W-1:0] l);
      @(negedge Clk);
      start = 1'b1; op = OP_MTHI; rs = h;
      @(negedge Clk);
      op = OP_MTLO; rs = l;
      @(negedge Clk);
      start = 1'b0;
   endtask

   // Counts busy negedges until done; flags any HI/LO change before done.
   task automatic wait_done(input logic [63:0] hold, output int bc, output int dn, output logic hold_bad);
      bc = 0; dn = 0; hold_bad = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge Clk);
         if (busy) bc++;
         if (done) begin
            dn++;
            break;
         end
         if ({hi, lo} !== hold) hold_bad = 1'b1;
      end
   endtask

   initial begin
      int         bc, dn, extra;
      logic       hb;

      vecs[0] = '{"mult_neg",     OP_MULT,  32'hFFFFFFFD, 32'd5,        32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{"multu_max",    OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0,  32'h00000001, 32'hFFFFFFFE};
      vecs[2] = '{"madd",         OP_MADD,  32'd3,        32'd4,        32'h0, 32'd10, 32'h0,        32'd22};
      vecs[3] = '{"msub",         OP_MSUB,  32'd2,        32'd20,       32'h0, 32'd22, 32'hFFFFFFFF, 32'hFFFFFFEE};
      vecs[4] = '{"div_neg",      OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h5, 32'h6,  32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[5] = '{"divu_zero",    OP_DIVU,  32'd7,        32'd0,        32'h0, 32'h0,  32'd7,        32'hFFFFFFFF};
      vecs[6] = '{"div_minneg",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h1,  32'h0,        32'h80000000};
      vecs[7] = '{"div_negdivsr", OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h0, 32'h0,  32'd1,        32'hFFFFFFFD};
      vecs[8] = '{"div_zero_sgn", OP_DIV,   32'hFFFFFFF9, 32'd0,        32'h0, 32'h0,  32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[9] = '{"mult_minneg",  OP_MULT,  32'h80000000, 32'h80000000, 32'h3, 32'h4,  32'h40000000, 32'h0};

      // Reset state
      repeat (2) @(negedge Clk);
      check("reset_hilo", {hi, lo}, 64'h0);
      check("reset_busy_done", {62'h0, busy, done}, 64'h0);
      Reset = 1'b0;

      // Table-driven engine ops
      foreach (vecs[k]) begin
         preload(vecs[k].pre_hi, vecs[k].pre_lo);
         check({vecs[k].name, "_preload"}, {hi, lo}, {vecs[k].pre_hi, vecs[k].pre_lo});
         pulse(vecs[k].op, vecs[k].rs, vecs[k].rt);
         wait_done({vecs[k].pre_hi, vecs[k].pre_lo}, bc, dn, hb);
         check({vecs[k].name, "_result"}, {hi, lo}, {vecs[k].exp_hi, vecs[k].exp_lo});
         check({vecs[k].name, "_busy_cycles"}, 64'(bc), 64'd33);
         check({vecs[k].name, "_done"}, 64'(dn), 64'd1);
         check({vecs[k].name, "_hold"}, {63'h0, hb}, 64'h0);
         @(negedge Clk);
         check({vecs[k].name, "_after"}, {62'h0, busy, done}, 64'h0);
      end

      // MTHI then MTLO on consecutive cycles
      preload(32'h11111111, 32'h22222222);
      @(negedge Clk);
      start = 1'b1; op = OP_MTHI; rs = 32'h12345678;
      @(negedge Clk);
      check("mthi_visible", {hi, lo}, {32'h12345678, 32'h22222222});
      check("mthi_busy", {63'h0, busy}, 64'h0);
      op = OP_MTLO; rs = 32'h9ABCDEF0;
      @(negedge Clk);
      start = 1'b0;
      check("mtlo_visible", {hi, lo}, {32'h12345678, 32'h9ABCDEF0});
      check("mtlo_busy_done", {62'h0, busy, done}, 64'h0);

      // Start while busy is ignored
      pulse(OP_DIV, 32'd100, 32'd7);
      repeat (9) @(negedge Clk);
      pulse(OP_MULT, 32'd6, 32'd7);
      wait_done({32'h12345678, 32'h9ABCDEF0}, bc, dn, hb);
      check("busy_ignore_result", {hi, lo}, {32'd2, 32'd14});
      check("busy_ignore_done", 64'(dn), 64'd1);
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         if (done || busy) extra++;
      end
      check("busy_ignore_no_rerun", 64'(extra), 64'd0);

      // Back-to-back: new start in the done cycle
      pulse(OP_MULTU, 32'd9, 32'd9);
      wait_done({32'd2, 32'd14}, bc, dn, hb);
      start = 1'b1; op = OP_MULTU; rs = 32'd10; rt = 32'd10;
      @(posedge Clk);
      #1 start = 1'b0;
      check("b2b_first", {hi, lo}, {32'd0, 32'd81});
      wait_done({32'd0, 32'd81}, bc, dn, hb);
      check("b2b_second", {hi, lo}, {32'd0, 32'd100});
      check("b2b_busy_cycles", 64'(bc), 64'd33);

      // Reset mid-RUN
      preload(32'hAAAA5555, 32'h5555AAAA);
      pulse(OP_MULT, 32'd123, 32'd456);
      repeat (14) @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      check("midreset_hilo", {hi, lo}, 64'h0);
      check("midreset_busy_done", {62'h0, busy, done}, 64'h0);
      @(negedge Clk);
      Reset = 1'b0;
      pulse(OP_MULT, 32'd6, 32'd7);
      wait_done(64'h0, bc, dn, hb);
      check("post_reset_mult", {hi, lo}, {32'd0, 32'd42});
      check("post_reset_busy_cycles", 64'(bc), 64'd33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Parametrised HI/LO register unit with an integrated iterative multiply/divide engine for the pipelined datapath. It accepts a single-cycle start request from the EX stage and runs signed or unsigned multiply, divide, multiply-accumulate or multiply-subtract over several cycles. It reports `busy` so the hazard unit can stall dependent MFHI/MFLO, and commits the 2×WIDTH result into architectural HI/LO. MTHI/MTLO writes complete in one cycle.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request strobe, sampled on rising `Clk`.
- `op`  in  3  operation code (package constants).
- `rs`  in  WIDTH  operand A (dividend / multiplicand / MTHI-MTLO data).
- `rt`  in  WIDTH  operand B (divisor / multiplier).
- `busy`  out  1  engine running; new `start` is ignored while high.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a new engine result.
- `hi`  out  WIDTH  architectural HI register.
- `lo`  out  WIDTH  architectural LO register.

## Operation
- Ops: MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI, MTLO.
- The FSM has three states:
  - IDLE: on `start` with an engine op, latch operand magnitudes, sign flags and op, then go to RUN.
  - RUN: WIDTH iterations, one per cycle. Multiply uses shift-add; divide uses restoring division.
  - FIX: apply the sign correction and the accumulate/subtract, write HI/LO, then go to IDLE.
- MTHI/MTLO: when IDLE and `start`, write `rs` into `hi`/`lo` at that edge. The other register is unchanged. No `busy`, no `done`.
- MULT/MULTU: {hi,lo} = rs×rt, signed or unsigned respectively, 2×WIDTH bits.
- MADD/MSUB: {hi,lo} = {hi,lo} ± signed(rs×rt), modulo 2^(2×WIDTH). Uses the HI/LO values present at FIX.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - DIV of the most negative value by −1: lo = most negative, hi = 0.
- Divide by zero (DIV or DIVU): hi = rs, lo = all ones. Still takes the full latency.
- `start` while busy: ignored entirely. No queueing, no error flag.
- Undefined `op` codes: ignored; no state change.
- `Reset` at any time, including mid-RUN, forces:
  - the FSM to IDLE;
  - `hi` = `lo` = 0;
  - `busy` = `done` = 0;
  - all internal accumulators to 0.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0.
- Engine op accepted at edge E0:
  - `busy`=1 from after E0 through E0+WIDTH+1.
  - RUN occupies edges E1..E_WIDTH; FIX is at edge E_WIDTH+1.
  - `hi`/`lo` update at edge E_WIDTH+1; `done`=1 for that following cycle only.
  - `busy` falls at the same edge.
- Total engine latency is WIDTH+1 edges after acceptance.
- A new `start` is legal in the cycle `done` is high and is accepted at the next edge (back-to-back throughput WIDTH+2 cycles).
- MTHI/MTLO: the value is visible the cycle after the accepting edge.
- `hi`/`lo` are register outputs and never glitch mid-operation. During RUN they hold the previous architectural values.

## Structure
- Shared package `hilo_pkg`:
  - op encoding constants: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO;
  - FSM state encodings IDLE/RUN/FIX.
- Sub-module `hilo_iter_core`: per-cycle shift-add / restoring-divide step on unsigned magnitudes plus its iteration counter.
- The top module owns the FSM, sign handling, accumulate/subtract, and the HI/LO registers.

## Test plan
- MULT rs=−3 (0xFFFFFFFD), rt=5 → after 33 edges: hi=0xFFFFFFFF, lo=0xFFFFFFF1, `done` pulses once, `busy` high exactly 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=2 → hi=0x00000001, lo=0xFFFFFFFE. Then MADD with `hi`=0, `lo`=10, rs=3, rt=4 → hi=0, lo=22. Then MSUB rs=2, rt=20 → hi=0xFFFFFFFF, lo=0xFFFFFFEE.
- DIV rs=−7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 → hi=7, lo=0xFFFFFFFF. DIV rs=0x80000000, rt=−1 → lo=0x80000000, hi=0.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0 on consecutive cycles → each visible the next cycle, other register unchanged, `busy` never asserts.
- `start` MULT asserted again at cycle 10 of a running DIV → ignored; the DIV result is committed correctly.
- Reset asserted mid-RUN (cycle 15) → `hi`=`lo`=0 and `busy`=0 immediately. A MULT 6×7 after release → lo=42, hi=0.
